// File: rtl/exu_alu_unit.sv
// exu_alu_unit: execute-stage ALU for the NPC core.
// Single-cycle ops (add/sub/compare/logic/shift) complete in one cycle.
// MUL/MULHU use a shift-add loop and DIV/DIVU/REM/REMU use restoring division.
// Both iterative paths take WIDTH steps, one bit per cycle.
// Results are returned over a valid/ready handshake.
module exu_alu_unit #(
  parameter int WIDTH      = 32,
  parameter int FUNC_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      alu_a,
  input  logic [WIDTH-1:0]      alu_b,
  input  logic [FUNC_WIDTH-1:0] alu_func,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_result,
  output logic                  busy
);

  // Function codes shared with the operand selector
  localparam logic [FUNC_WIDTH-1:0] F_NO    = FUNC_WIDTH'(0);
  localparam logic [FUNC_WIDTH-1:0] F_ADD_S = FUNC_WIDTH'(1);
  localparam logic [FUNC_WIDTH-1:0] F_SUB_S = FUNC_WIDTH'(2);
  localparam logic [FUNC_WIDTH-1:0] F_EQ    = FUNC_WIDTH'(3);
  localparam logic [FUNC_WIDTH-1:0] F_SLT   = FUNC_WIDTH'(4);
  localparam logic [FUNC_WIDTH-1:0] F_SLTU  = FUNC_WIDTH'(5);
  localparam logic [FUNC_WIDTH-1:0] F_AND   = FUNC_WIDTH'(6);
  localparam logic [FUNC_WIDTH-1:0] F_OR    = FUNC_WIDTH'(7);
  localparam logic [FUNC_WIDTH-1:0] F_XOR   = FUNC_WIDTH'(8);
  localparam logic [FUNC_WIDTH-1:0] F_SLL   = FUNC_WIDTH'(9);
  localparam logic [FUNC_WIDTH-1:0] F_SRL   = FUNC_WIDTH'(10);
  localparam logic [FUNC_WIDTH-1:0] F_SRA   = FUNC_WIDTH'(11);
  localparam logic [FUNC_WIDTH-1:0] F_MUL   = FUNC_WIDTH'(12);
  localparam logic [FUNC_WIDTH-1:0] F_MULHU = FUNC_WIDTH'(13);
  localparam logic [FUNC_WIDTH-1:0] F_DIV   = FUNC_WIDTH'(14);
  localparam logic [FUNC_WIDTH-1:0] F_DIVU  = FUNC_WIDTH'(15);
  localparam logic [FUNC_WIDTH-1:0] F_REM   = FUNC_WIDTH'(16);
  localparam logic [FUNC_WIDTH-1:0] F_REMU  = FUNC_WIDTH'(17);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state;
  logic [FUNC_WIDTH-1:0]   func_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [2*WIDTH-1:0]      acc_q;
  logic [2*WIDTH-1:0]      mcand_q;
  logic [WIDTH-1:0]        mplier_q;
  logic [WIDTH-1:0]        rem_q;
  logic [WIDTH-1:0]        quot_q;
  logic [WIDTH-1:0]        divisor_q;
  logic                    qneg_q;
  logic                    rneg_q;

  // Single-cycle result, including the divide-by-zero shortcut for div/rem codes
  function automatic logic [WIDTH-1:0] single_op(input logic [FUNC_WIDTH-1:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (f)
      F_ADD_S:        r = a + b;
      F_SUB_S:        r = a - b;
      F_EQ:           r = {{(WIDTH-1){1'b0}}, (a == b)};
      F_SLT:          r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      F_SLTU:         r = {{(WIDTH-1){1'b0}}, (a < b)};
      F_AND:          r = a & b;
      F_OR:           r = a | b;
      F_XOR:          r = a ^ b;
      F_SLL:          r = a << b[SH_W-1:0];
      F_SRL:          r = a >> b[SH_W-1:0];
      F_SRA:          r = $unsigned(sa >>> b[SH_W-1:0]);
      F_DIV, F_DIVU:  r = '1;
      F_REM, F_REMU:  r = a;
      default:        r = '0;
    endcase
    return r;
  endfunction

  // Two's-complement magnitude of a signed operand
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  logic is_mul;
  logic is_div;
  logic is_sdiv;
  logic take_iter;

  // Classify the incoming function; divides by zero stay on the single-cycle path
  always_comb begin
    is_mul    = (alu_func == F_MUL) || (alu_func == F_MULHU);
    is_sdiv   = (alu_func == F_DIV) || (alu_func == F_REM);
    is_div    = is_sdiv || (alu_func == F_DIVU) || (alu_func == F_REMU);
    take_iter = is_mul || (is_div && (alu_b != '0));
  end

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_dif;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quot_nxt;
  logic [WIDTH-1:0]   iter_result;

  // One multiply step and one restoring-division step, plus the final-step result mux
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    rem_sh  = {rem_q, quot_q[WIDTH-1]};
    rem_dif = rem_sh - {1'b0, divisor_q};
    if (!rem_dif[WIDTH]) begin
      rem_nxt  = rem_dif[WIDTH-1:0];
      quot_nxt = {quot_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt  = rem_sh[WIDTH-1:0];
      quot_nxt = {quot_q[WIDTH-2:0], 1'b0};
    end
    case (func_q)
      F_MUL:   iter_result = acc_nxt[WIDTH-1:0];
      F_MULHU: iter_result = acc_nxt[2*WIDTH-1:WIDTH];
      F_DIVU:  iter_result = quot_nxt;
      F_REMU:  iter_result = rem_nxt;
      F_DIV:   iter_result = qneg_q ? (~quot_nxt + 1'b1) : quot_nxt;
      F_REM:   iter_result = rneg_q ? (~rem_nxt + 1'b1) : rem_nxt;
      default: iter_result = '0;
    endcase
  end

  // Control FSM with registered result and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      func_q     <= F_NO;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      out_valid  <= 1'b0;
      alu_result <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            func_q <= alu_func;
            if (take_iter) begin
              cnt_q     <= '0;
              acc_q     <= '0;
              mcand_q   <= {{WIDTH{1'b0}}, alu_a};
              mplier_q  <= alu_b;
              rem_q     <= '0;
              quot_q    <= magnitude(alu_a, is_sdiv);
              divisor_q <= magnitude(alu_b, is_sdiv);
              qneg_q    <= is_sdiv && (alu_a[WIDTH-1] ^ alu_b[WIDTH-1]);
              rneg_q    <= is_sdiv && alu_a[WIDTH-1];
              state     <= CALC;
            end else begin
              alu_result <= single_op(alu_func, alu_a, alu_b);
              out_valid  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        CALC: begin
          acc_q    <= acc_nxt;
          mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          rem_q    <= rem_nxt;
          quot_q   <= quot_nxt;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            alu_result <= iter_result;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Handshake status
  always_comb begin
    in_ready = (state == IDLE) && !rst;
    busy     = (state != IDLE);
  end

endmodule

// File: tb/tb_exu_alu_unit.sv
// tb_exu_alu_unit: directed and randomized checks of exu_alu_unit against a
// behavioural reference written with plain integer arithmetic.
module tb_exu_alu_unit;

  localparam logic [4:0] F_ADD_S = 5'd1,  F_SUB_S = 5'd2,  F_EQ   = 5'd3,  F_SLT  = 5'd4;
  localparam logic [4:0] F_SLTU  = 5'd5,  F_AND   = 5'd6,  F_OR   = 5'd7,  F_XOR  = 5'd8;
  localparam logic [4:0] F_SLL   = 5'd9,  F_SRL   = 5'd10, F_SRA  = 5'd11, F_MUL  = 5'd12;
  localparam logic [4:0] F_MULHU = 5'd13, F_DIV   = 5'd14, F_DIVU = 5'd15, F_REM  = 5'd16;
  localparam logic [4:0] F_REMU  = 5'd17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_a = '0;
  logic [31:0] alu_b = '0;
  logic [4:0]  alu_func = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] alu_result;
  logic        busy;

  int checks = 0;
  int failures = 0;

  exu_alu_unit #(.WIDTH(32), .FUNC_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    longint   sa, sb;
    bit [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = {32'b0, a} * {32'b0, b};
    case (f)
      F_ADD_S: return a + b;
      F_SUB_S: return a - b;
      F_EQ:    return (a == b) ? 32'd1 : 32'd0;
      F_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      F_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_XOR:   return a ^ b;
      F_SLL:   return a << b[4:0];
      F_SRL:   return a >> b[4:0];
      F_SRA:   return 32'(sa >>> b[4:0]);
      F_MUL:   return p[31:0];
      F_MULHU: return p[63:32];
      F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REMU:  return (b == 0) ? a : a % b;
      F_DIV:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      F_REM:   return (b == 0) ? a : 32'(sa % sb);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input int hold, input bit chk_busy);
    logic [31:0] e;
    int n;
    e = ref_alu(f, a, b);
    @(negedge clk);
    alu_func = f; alu_a = a; alu_b = b; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_a = $urandom; alu_b = $urandom; alu_func = 5'($urandom);
    n = 1;
    while (!out_valid && n < 200) begin
      if (chk_busy) chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_result"}, alu_result, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_result"}, alu_result, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int sent, got, cyc, seen;
    bit acc, hs;
    logic [31:0] q[$];

    // reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // single-cycle ops
    do_op("add_wrap", F_ADD_S, 32'hFFFF_FFFF, 32'd2, 1, 5, 1'b0);
    do_op("sub", F_SUB_S, 32'd3, 32'd5, 1, 0, 1'b0);
    do_op("eq", F_EQ, 32'd7, 32'd7, 1, 0, 1'b0);
    do_op("slt", F_SLT, 32'h8000_0000, 32'd1, 1, 0, 1'b0);
    do_op("sltu", F_SLTU, 32'h8000_0000, 32'd1, 1, 0, 1'b0);
    do_op("sra", F_SRA, 32'h8000_0000, 32'd31, 1, 0, 1'b0);
    do_op("sll", F_SLL, 32'h0000_0003, 32'h0000_0104, 1, 0, 1'b0);
    do_op("undef", 5'd25, 32'h1234_5678, 32'h1, 1, 0, 1'b0);

    // iterative ops
    do_op("mul", F_MUL, 32'hFFFF_FFFF, 32'd2, 33, 0, 1'b1);
    do_op("mulhu", F_MULHU, 32'hFFFF_FFFF, 32'd2, 33, 2, 1'b0);
    do_op("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 33, 0, 1'b0);
    do_op("rem_neg", F_REM, 32'hFFFF_FFF9, 32'd2, 33, 0, 1'b0);
    do_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0, 1'b0);
    do_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 33, 0, 1'b0);
    do_op("divu_0", F_DIVU, 32'd100, 32'd0, 1, 0, 1'b0);
    do_op("remu_0", F_REMU, 32'd100, 32'd0, 1, 0, 1'b0);

    // flush at cycle 10 of a DIVU
    @(negedge clk);
    alu_func = F_DIVU; alu_a = 32'd1000; alu_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("flush_no_valid", 32'(seen), 32'd0);
    do_op("add_after_flush", F_ADD_S, 32'd40, 32'd2, 1, 0, 1'b0);

    // flush beats out_ready in DONE
    @(negedge clk);
    alu_func = F_ADD_S; alu_a = 32'd5; alu_b = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    chk("fd_valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b0;
    chk("fd_drop_valid", 32'(out_valid), 32'd0);
    chk("fd_busy", 32'(busy), 32'd0);

    // flush blocks accept in IDLE
    @(negedge clk);
    alu_func = F_ADD_S; alu_a = 32'd1; alu_b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    chk("fi_busy", 32'(busy), 32'd0);
    chk("fi_valid", 32'(out_valid), 32'd0);

    // reset mid-MUL
    @(negedge clk);
    alu_func = F_MUL; alu_a = 32'hDEAD_BEEF; alu_b = 32'h1234_5678; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    chk("rmid_out_valid", 32'(out_valid), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_result", alu_result, 32'd0);
    chk("rmid_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("rmid_ready_after", 32'(in_ready), 32'd1);

    // randomized stream under random back-pressure
    sent = 0; got = 0; cyc = 0;
    @(posedge clk); #1;
    while (got < 50 && cyc < 20000) begin
      if (!in_valid && sent < 50 && $urandom_range(0, 1) == 1) begin
        alu_func = 5'($urandom_range(0, 19));
        alu_a = pick();
        alu_b = pick();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      if (hs) begin
        if (q.size() == 0) chk("stream_extra", 32'd1, 32'd0);
        else chk("stream_result", alu_result, q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back(ref_alu(alu_func, alu_a, alu_b));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        in_valid = 1'b0;
        alu_a = $urandom; alu_b = $urandom; alu_func = 5'($urandom);
      end
    end
    out_ready = 1'b0;
    chk("stream_count", 32'(got), 32'd50);
    chk("stream_left", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
